data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter (A = datapath, B = debug/UART) in front of a single-port data memory.
// Build option: define DATA_MEM_ARB_RR_EN for round-robin arbitration; fixed A priority otherwise.
module data_mem_arbiter #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 11,
  parameter int N_DATOS = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_a_req,
  input  logic               i_a_wr,
  input  logic [NB_ADDR-1:0] i_a_addr,
  input  logic [NB_DATA-1:0] i_a_data,
  output logic               o_a_gnt,
  output logic               o_a_err,
  output logic               o_a_rvalid,
  output logic [NB_DATA-1:0] o_a_rdata,
  input  logic               i_b_req,
  input  logic               i_b_wr,
  input  logic [NB_ADDR-1:0] i_b_addr,
  input  logic [NB_DATA-1:0] i_b_data,
  output logic               o_b_gnt,
  output logic               o_b_err,
  output logic               o_b_rvalid,
  output logic [NB_DATA-1:0] o_b_rdata,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic               o_mem_wr,
  output logic               o_mem_rd,
  input  logic [NB_DATA-1:0] i_mem_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;

  localparam logic [NB_ADDR:0] ADDR_LIMIT = (NB_ADDR+1)'(N_DATOS);

  state_t               state_q, state_d;
  logic                 win_b_q, win_b_d;
  logic                 a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                 a_err_q, a_err_d, b_err_q, b_err_d;
  logic                 a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [NB_DATA-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [NB_ADDR-1:0]   mem_addr_q, mem_addr_d;
  logic [NB_DATA-1:0]   mem_data_q, mem_data_d;
  logic                 mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;

  logic                 any_req, pick_b, sel_wr, sel_in_range;
  logic [NB_ADDR-1:0]   sel_addr;
  logic [NB_DATA-1:0]   sel_data;

  assign any_req      = i_a_req | i_b_req;
  assign sel_wr       = pick_b ? i_b_wr   : i_a_wr;
  assign sel_addr     = pick_b ? i_b_addr : i_a_addr;
  assign sel_data     = pick_b ? i_b_data : i_a_data;
  assign sel_in_range = {1'b0, sel_addr} < ADDR_LIMIT;

`ifdef DATA_MEM_ARB_RR_EN
  // prefer_b_q: on a tie B wins; flips to the loser on every grant, error grants included
  logic prefer_b_q, prefer_b_d;

  assign pick_b = i_b_req & (~i_a_req | prefer_b_q);

  always_comb begin
    prefer_b_d = prefer_b_q;
    if (state_q == IDLE && any_req) prefer_b_d = ~pick_b;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) prefer_b_q <= 1'b0;
    else          prefer_b_q <= prefer_b_d;
  end
`else
  assign pick_b = i_b_req & ~i_a_req;
`endif

  // Outputs are computed for the state being entered so that they register alongside it.
  always_comb begin
    state_d    = state_q;
    win_b_d    = win_b_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = ISSUE;
          win_b_d    = pick_b;
          a_gnt_d    = ~pick_b;
          b_gnt_d    = pick_b;
          mem_addr_d = sel_addr;
          mem_data_d = sel_data;
          if (sel_in_range) begin
            mem_wr_d = sel_wr;
            mem_rd_d = ~sel_wr;
          end else begin
            a_err_d = ~pick_b;
            b_err_d = pick_b;
          end
        end
      end
      ISSUE: begin
        state_d = mem_rd_q ? CAPTURE : IDLE;
      end
      CAPTURE: begin
        state_d = IDLE;
        if (win_b_q) begin
          b_rdata_d  = i_mem_data;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = i_mem_data;
          a_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      win_b_q    <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_b_q    <= win_b_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign o_a_gnt    = a_gnt_q;
  assign o_a_err    = a_err_q;
  assign o_a_rvalid = a_rvalid_q;
  assign o_a_rdata  = a_rdata_q;
  assign o_b_gnt    = b_gnt_q;
  assign o_b_err    = b_err_q;
  assign o_b_rvalid = b_rvalid_q;
  assign o_b_rdata  = b_rdata_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_wr   = mem_wr_q;
  assign o_mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: transaction-level model of arbitration, latency and memory contents.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_wr, b_req, b_wr;
  logic [10:0] a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        o_a_gnt, o_a_err, o_a_rvalid, o_b_gnt, o_b_err, o_b_rvalid;
  logic [15:0] o_a_rdata, o_b_rdata;
  logic [10:0] o_mem_addr;
  logic [15:0] o_mem_data;
  logic        o_mem_wr, o_mem_rd;
  logic [15:0] i_mem_data;

  int tests_run    = 0;
  int tests_failed = 0;

  // environment memory, cleared only at start of run
  logic        mem_clr;
  logic [15:0] env_mem [8];

  // reference model state
  logic [15:0] model_mem [8];
  logic [15:0] exp_rdata [2];
  bit          last_b;

  data_mem_arbiter #(.NB_DATA(16), .NB_ADDR(11), .N_DATOS(8)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_a_req(a_req), .i_a_wr(a_wr), .i_a_addr(a_addr), .i_a_data(a_data),
    .o_a_gnt(o_a_gnt), .o_a_err(o_a_err), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
    .i_b_req(b_req), .i_b_wr(b_wr), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_b_gnt(o_b_gnt), .o_b_err(o_b_err), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_wr(o_mem_wr), .o_mem_rd(o_mem_rd),
    .i_mem_data(i_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) env_mem[i] <= 16'h0;
      i_mem_data <= 16'h0;
    end else begin
      if (o_mem_wr) env_mem[o_mem_addr[2:0]] <= o_mem_data;
      i_mem_data <= o_mem_rd ? env_mem[o_mem_addr[2:0]] : 16'h0;
    end
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // winner chosen from the rules: single requester wins; on a tie A (fixed) or the one not granted last
  function automatic bit pick_winner();
`ifdef DATA_MEM_ARB_RR_EN
    if (a_req && b_req) return !last_b;
`else
    if (a_req && b_req) return 1'b0;
`endif
    return b_req;
  endfunction

  task automatic chk_quiet(input string tag);
    chk(tag, 32'({o_a_gnt, o_b_gnt, o_a_err, o_b_err, o_mem_rd, o_mem_wr, o_a_rvalid, o_b_rvalid}), 0);
  endtask

  // One transaction: requests are already driven; the DUT samples them at the next posedge.
  task automatic serve(input bit hold);
    bit          w, wr, err;
    logic [10:0] addr;
    logic [15:0] data;
    w    = pick_winner();
    wr   = w ? b_wr : a_wr;
    addr = w ? b_addr : a_addr;
    data = w ? b_data : a_data;
    err  = (addr >= 11'd8);
    @(negedge clk);
    chk("gnt_a", 32'(o_a_gnt), 32'(!w));
    chk("gnt_b", 32'(o_b_gnt), 32'(w));
    chk("err_a", 32'(o_a_err), 32'(!w && err));
    chk("err_b", 32'(o_b_err), 32'(w && err));
    chk("mem_wr", 32'(o_mem_wr), 32'(wr && !err));
    chk("mem_rd", 32'(o_mem_rd), 32'(!wr && !err));
    chk("rvalid_at_gnt", 32'({o_a_rvalid, o_b_rvalid}), 0);
    if (!err) chk("mem_addr", 32'(o_mem_addr), 32'(addr));
    if (wr && !err) chk("mem_data", 32'(o_mem_data), 32'(data));
    $display("[TB] t=%0t grant %s %s addr=%0d data=%h err=%0d", $time, w ? "B" : "A",
             wr ? "WR" : "RD", addr, data, err);
    last_b = w;
    if (wr && !err) model_mem[addr[2:0]] = data;
    if (!hold) begin
      if (w) b_req = 1'b0;
      else   a_req = 1'b0;
    end
    @(negedge clk);
    chk_quiet(wr || err ? "idle_after_issue" : "capture_quiet");
    if (!wr && !err) begin
      @(negedge clk);
      exp_rdata[w] = model_mem[addr[2:0]];
      chk("rvalid_a", 32'(o_a_rvalid), 32'(!w));
      chk("rvalid_b", 32'(o_b_rvalid), 32'(w));
      chk("rdata_a", 32'(o_a_rdata), 32'(exp_rdata[0]));
      chk("rdata_b", 32'(o_b_rdata), 32'(exp_rdata[1]));
      chk("strobes_at_rvalid", 32'({o_a_gnt, o_b_gnt, o_mem_rd, o_mem_wr}), 0);
    end
  endtask

  task automatic set_a(input logic req, input logic wr, input logic [10:0] addr, input logic [15:0] data);
    a_req = req; a_wr = wr; a_addr = addr; a_data = data;
  endtask

  task automatic set_b(input logic req, input logic wr, input logic [10:0] addr, input logic [15:0] data);
    b_req = req; b_wr = wr; b_addr = addr; b_data = data;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_clr = 1'b1;
    set_a(1'b0, 1'b0, 11'd0, 16'h0);
    set_b(1'b0, 1'b0, 11'd0, 16'h0);
    for (int i = 0; i < 8; i++) model_mem[i] = 16'h0;
    exp_rdata[0] = 16'h0;
    exp_rdata[1] = 16'h0;
    last_b = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk_quiet("reset_pulses");
    chk("reset_mem_addr", 32'(o_mem_addr), 0);
    chk("reset_mem_data", 32'(o_mem_data), 0);
    chk("reset_rdata", 32'({o_a_rdata, o_b_rdata}), 0);
    rst_n = 1'b1;
    mem_clr = 1'b0;

    // A writes 0x1234 to addr 3, then reads it back
    set_a(1'b1, 1'b1, 11'd3, 16'h1234);
    serve(1'b0);
    set_a(1'b1, 1'b0, 11'd3, 16'h0);
    serve(1'b0);
    chk("a_readback_1234", 32'(o_a_rdata), 32'h1234);

    // seed addrs 1 and 2, then both requesters read continuously
    set_a(1'b1, 1'b1, 11'd1, 16'hAAAA);
    serve(1'b0);
    set_b(1'b1, 1'b1, 11'd2, 16'hBBBB);
    serve(1'b0);
    set_a(1'b1, 1'b0, 11'd1, 16'h0);
    set_b(1'b1, 1'b0, 11'd2, 16'h0);
    repeat (4) serve(1'b1);
    set_a(1'b0, 1'b0, 11'd0, 16'h0);
    set_b(1'b0, 1'b0, 11'd0, 16'h0);
    @(negedge clk);

    // B writes out of range: error grant, memory untouched
    set_b(1'b1, 1'b1, 11'd8, 16'hDEAD);
    serve(1'b0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk("mem_after_err", 32'(env_mem[i]), 32'(model_mem[i]));

    // B back-to-back writes to 0..7 with the request held
    for (int i = 0; i < 8; i++) begin
      set_b(1'b1, 1'b1, 11'(i), 16'($urandom));
      serve(1'b1);
    end
    b_req = 1'b0;

    // loser drops its request before being granted: nothing more happens
    set_a(1'b1, 1'b1, 11'd5, 16'h5555);
    set_b(1'b1, 1'b1, 11'd6, 16'h6666);
    serve(1'b0);
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_quiet("dropped_request_ignored");
    end

    // reset during CAPTURE of an A read
    set_a(1'b1, 1'b0, 11'd3, 16'h0);
    @(negedge clk);
    chk("abort_gnt_a", 32'(o_a_gnt), 1);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rvalid_a", 32'(o_a_rvalid), 0);
    chk("abort_rdata", 32'({o_a_rdata, o_b_rdata}), 0);
    chk_quiet("abort_pulses");
    exp_rdata[0] = 16'h0;
    exp_rdata[1] = 16'h0;
    last_b = 1'b1;
    rst_n = 1'b1;
    set_a(1'b1, 1'b0, 11'd3, 16'h0);
    serve(1'b0);

    // randomized traffic
    repeat (40) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 9)), 16'($urandom));
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 9)), 16'($urandom));
      if (!a_req && !b_req) a_req = 1'b1;
      serve(1'b0);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) chk("final_mem", 32'(env_mem[i]), 32'(model_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
